// File: rtl/imm_pack.sv
// Immediate packer: encodes a 32-bit immediate into RISC-V instruction fields on top of a
// base word, drops out-of-range requests and streams legal words with a running address.
module imm_pack #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      base_instr,
  input  logic [31:0]      imm,
  input  logic [2:0]       imm_src,
  input  logic             restart,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [2:0] {
    SRC_I     = 3'b000,
    SRC_S     = 3'b001,
    SRC_B     = 3'b010,
    SRC_J     = 3'b011,
    SRC_U     = 3'b100,
    SRC_SHAMT = 3'b101
  } imm_src_e;

  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic        ready_q;
  logic        s1_valid;
  logic        s1_legal;
  logic [31:0] s1_word;
  logic [31:0] addr_q;
  logic [IDX_W-1:0] idx_q;

  logic        pk_legal;
  logic [31:0] pk_word;
  logic        fits_12;
  logic        fits_13;
  logic        fits_21;
  logic        s1_moves;
  logic        accept;
  logic        word_moves;
  logic        drop;
  logic        out_fire;

  // Sign-extension checks: the immediate fits in N bits when bits [31:N-1] are all equal.
  assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    pk_word  = base_instr;
    pk_legal = 1'b0;
    case (imm_src)
      SRC_I: begin
        pk_word  = {imm[11:0], base_instr[19:0]};
        pk_legal = fits_12;
      end
      SRC_S: begin
        pk_word  = {imm[11:5], base_instr[24:12], imm[4:0], base_instr[6:0]};
        pk_legal = fits_12;
      end
      SRC_B: begin
        pk_word  = {imm[12], imm[10:5], base_instr[24:12], imm[4:1], imm[11], base_instr[6:0]};
        pk_legal = ~imm[0] & fits_13;
      end
      SRC_J: begin
        pk_word  = {imm[20], imm[10:1], imm[11], imm[19:12], base_instr[11:0]};
        pk_legal = ~imm[0] & fits_21;
      end
      SRC_U: begin
        pk_word  = {imm[31:12], base_instr[11:0]};
        pk_legal = ~(|imm[11:0]);
      end
      SRC_SHAMT: begin
        pk_word  = {base_instr[31:25], imm[4:0], base_instr[19:0]};
        pk_legal = ~(|imm[31:5]);
      end
      default: begin
        pk_word  = base_instr;
        pk_legal = 1'b0;
      end
    endcase
  end

  assign out_fire   = out_valid & out_ready;
  assign s1_moves   = ~out_valid | out_fire;
  assign in_ready   = ready_q & (~s1_valid | s1_moves);
  assign accept     = in_valid & in_ready;
  assign word_moves = s1_moves & s1_valid & s1_legal;
  assign drop       = s1_moves & s1_valid & ~s1_legal;

  // Stage 1 holds the packed word and its legality until stage 2 can take it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      s1_valid <= 1'b0;
      s1_legal <= 1'b0;
      s1_word  <= 32'h0;
    end else begin
      ready_q <= 1'b1;
      if (in_ready) begin
        s1_valid <= accept;
        s1_legal <= pk_legal;
        s1_word  <= pk_word;
      end
    end
  end

  // Stage 2 is the output register; it keeps its word and address steady while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_addr  <= BASE_ADDR;
    end else if (s1_moves) begin
      out_valid <= word_moves;
      if (word_moves) begin
        out_instr <= s1_word;
        out_addr  <= addr_q;
      end
    end
  end

  // A word moving on the same edge as restart still takes the old address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= BASE_ADDR;
      idx_q  <= '0;
    end else if (restart) begin
      addr_q <= BASE_ADDR;
      idx_q  <= '0;
    end else if (word_moves) begin
      if (idx_q == LAST_IDX) begin
        addr_q <= BASE_ADDR;
        idx_q  <= '0;
      end else begin
        addr_q <= addr_q + 32'd4;
        idx_q  <= idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      word_cnt   <= '0;
    end else begin
      err_pulse <= drop;
      if (drop) begin
        err_sticky <= 1'b1;
      end
      if (drop && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      if (out_fire && (word_cnt != {CNT_W{1'b1}})) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// Directed bench for imm_pack: field packing, range drops, backpressure, address wrap,
// restart and mid-stream reset, with hand-computed expected values.
module tb_imm_pack;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] base_instr;
  logic [31:0] imm;
  logic [2:0]  imm_src;
  logic        restart;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_pulse;
  logic        err_sticky;
  logic [15:0] err_cnt;
  logic [15:0] word_cnt;

  int cmpCount = 0;
  int errCount = 0;

  imm_pack #(
    .BASE_ADDR(BASE),
    .DEPTH    (4),
    .CNT_W    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .base_instr(base_instr),
    .imm       (imm),
    .imm_src   (imm_src),
    .restart   (restart),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmpCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] i, input logic [2:0] s);
    base_instr = b;
    imm        = i;
    imm_src    = s;
    in_valid   = 1'b1;
  endtask

  task automatic doReset();
    in_valid  = 1'b0;
    restart   = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One request into an empty pipeline with out_ready high; checks the two-edge latency.
  task automatic sendAndExpect(input string tag, input logic [31:0] b, input logic [31:0] i,
                               input logic [2:0] s, input logic [31:0] expInstr,
                               input logic [31:0] expAddr);
    applyStimulus(b, i, s);
    checkOutput({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput({tag, "_early"}, {31'b0, out_valid}, 32'd0);
    tick();
    checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({tag, "_instr"}, out_instr, expInstr);
    checkOutput({tag, "_addr"}, out_addr, expAddr);
    tick();
    checkOutput({tag, "_gone"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic sendAndDrop(input string tag, input logic [31:0] b, input logic [31:0] i,
                             input logic [2:0] s, input logic [15:0] expErrCnt);
    applyStimulus(b, i, s);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput({tag, "_pulse"}, {31'b0, err_pulse}, 32'd1);
    checkOutput({tag, "_novalid"}, {31'b0, out_valid}, 32'd0);
    checkOutput({tag, "_errcnt"}, {16'b0, err_cnt}, {16'b0, expErrCnt});
    checkOutput({tag, "_sticky"}, {31'b0, err_sticky}, 32'd1);
    tick();
    checkOutput({tag, "_pulse_end"}, {31'b0, err_pulse}, 32'd0);
    checkOutput({tag, "_stillnone"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    base_instr = 32'h0;
    imm        = 32'h0;
    imm_src    = 3'b000;
    restart    = 1'b0;
    out_ready  = 1'b1;

    // Reset state
    tick();
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'h0);
    checkOutput("rst_out_addr", out_addr, BASE);
    checkOutput("rst_err_pulse", {31'b0, err_pulse}, 32'd0);
    checkOutput("rst_err_sticky", {31'b0, err_sticky}, 32'd0);
    checkOutput("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
    checkOutput("rst_word_cnt", {16'b0, word_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // I-type and S-type
    sendAndExpect("I_neg1", 32'h0000_0013, 32'hFFFF_FFFF, 3'b000, 32'hFFF0_0013, BASE);
    sendAndDrop("I_2048", 32'h0000_0013, 32'h0000_0800, 3'b000, 16'd1);
    sendAndExpect("I_m2048", 32'h0000_0013, 32'hFFFF_F800, 3'b000, 32'h8000_0013, BASE + 32'h4);
    sendAndExpect("S_m8", 32'h0000_2023, 32'hFFFF_FFF8, 3'b001, 32'hFE00_2C23, BASE + 32'h8);
    checkOutput("IS_word_cnt", {16'b0, word_cnt}, 32'd3);

    // B-type
    doReset();
    sendAndExpect("B_m4", 32'h0000_0063, 32'hFFFF_FFFC, 3'b010, 32'hFE00_0EE3, BASE);
    sendAndDrop("B_odd", 32'h0000_0063, 32'h0000_0003, 3'b010, 16'd1);
    sendAndDrop("B_4096", 32'h0000_0063, 32'h0000_1000, 3'b010, 16'd2);
    sendAndExpect("B_4094", 32'h0000_0063, 32'h0000_0FFE, 3'b010, 32'h7E00_0FE3, BASE + 32'h4);

    // J, U, shamt and illegal selectors
    doReset();
    sendAndExpect("J_2048", 32'h0000_006F, 32'h0000_0800, 3'b011, 32'h0010_006F, BASE);
    sendAndExpect("U_ok", 32'h0000_0037, 32'h1234_5000, 3'b100, 32'h1234_5037, BASE + 32'h4);
    sendAndDrop("U_low", 32'h0000_0037, 32'h1234_5001, 3'b100, 16'd1);
    sendAndExpect("SH_5", 32'h4000_5013, 32'h0000_0005, 3'b101, 32'h4050_5013, BASE + 32'h8);
    sendAndDrop("SH_32", 32'h4000_5013, 32'h0000_0020, 3'b101, 16'd2);
    sendAndDrop("SRC_110", 32'h0000_0013, 32'h0000_0001, 3'b110, 16'd3);
    sendAndExpect("J_m2", 32'h0000_006F, 32'hFFFF_FFFE, 3'b011, 32'hFFFF_F06F, BASE + 32'hC);
    checkOutput("JU_word_cnt", {16'b0, word_cnt}, 32'd4);

    // Backpressure: two accepts fill both stages, then in_ready drops
    doReset();
    out_ready = 1'b0;
    applyStimulus(32'h0000_0013, 32'd1, 3'b000);
    checkOutput("bp_rdy0", {31'b0, in_ready}, 32'd1);
    tick();
    applyStimulus(32'h0000_0013, 32'd2, 3'b000);
    checkOutput("bp_rdy1", {31'b0, in_ready}, 32'd1);
    tick();
    applyStimulus(32'h0000_0013, 32'd3, 3'b000);
    checkOutput("bp_rdy2_low", {31'b0, in_ready}, 32'd0);
    checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("bp_instr0", out_instr, 32'h0010_0013);
    checkOutput("bp_addr0", out_addr, BASE);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("bp_stall_rdy", {31'b0, in_ready}, 32'd0);
      checkOutput("bp_stall_instr", out_instr, 32'h0010_0013);
      checkOutput("bp_stall_addr", out_addr, BASE);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_rdy_release", {31'b0, in_ready}, 32'd1);
    tick();
    applyStimulus(32'h0000_0013, 32'd4, 3'b000);
    checkOutput("bp_instr1", out_instr, 32'h0020_0013);
    checkOutput("bp_addr1", out_addr, BASE + 32'h4);
    tick();
    in_valid = 1'b0;
    checkOutput("bp_instr2", out_instr, 32'h0030_0013);
    checkOutput("bp_addr2", out_addr, BASE + 32'h8);
    tick();
    checkOutput("bp_valid3", {31'b0, out_valid}, 32'd1);
    checkOutput("bp_instr3", out_instr, 32'h0040_0013);
    checkOutput("bp_addr3", out_addr, BASE + 32'hC);
    tick();
    checkOutput("bp_drained", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_word_cnt", {16'b0, word_cnt}, 32'd4);

    // Address wrap after four words, then restart coinciding with a move
    doReset();
    sendAndExpect("wr0", 32'h0000_0013, 32'd1, 3'b000, 32'h0010_0013, BASE);
    sendAndExpect("wr1", 32'h0000_0013, 32'd2, 3'b000, 32'h0020_0013, BASE + 32'h4);
    sendAndExpect("wr2", 32'h0000_0013, 32'd3, 3'b000, 32'h0030_0013, BASE + 32'h8);
    sendAndExpect("wr3", 32'h0000_0013, 32'd4, 3'b000, 32'h0040_0013, BASE + 32'hC);
    sendAndExpect("wr4", 32'h0000_0013, 32'd5, 3'b000, 32'h0050_0013, BASE);
    applyStimulus(32'h0000_0013, 32'd6, 3'b000);
    tick();
    in_valid = 1'b0;
    restart  = 1'b1;
    tick();
    restart = 1'b0;
    checkOutput("rs_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("rs_instr", out_instr, 32'h0060_0013);
    checkOutput("rs_old_addr", out_addr, BASE + 32'h4);
    tick();
    sendAndExpect("rs_next", 32'h0000_0013, 32'd7, 3'b000, 32'h0070_0013, BASE);

    // Reset with both stages full
    doReset();
    sendAndExpect("mr_w", 32'h0000_0013, 32'd1, 3'b000, 32'h0010_0013, BASE);
    sendAndDrop("mr_bad", 32'h0000_0013, 32'h0000_1000, 3'b000, 16'd1);
    out_ready = 1'b0;
    applyStimulus(32'h0000_0013, 32'd2, 3'b000);
    tick();
    applyStimulus(32'h0000_0013, 32'd3, 3'b000);
    tick();
    in_valid = 1'b0;
    checkOutput("mr_full_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("mr_full_rdy", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    checkOutput("mr_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mr_out_instr", out_instr, 32'h0);
    checkOutput("mr_out_addr", out_addr, BASE);
    checkOutput("mr_word_cnt", {16'b0, word_cnt}, 32'd0);
    checkOutput("mr_err_cnt", {16'b0, err_cnt}, 32'd0);
    checkOutput("mr_err_sticky", {31'b0, err_sticky}, 32'd0);
    checkOutput("mr_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    checkOutput("mr_flush1", {31'b0, out_valid}, 32'd0);
    tick();
    checkOutput("mr_flush2", {31'b0, out_valid}, 32'd0);
    sendAndExpect("mr_after", 32'h0000_0013, 32'd9, 3'b000, 32'h0090_0013, BASE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
